// File: rtl/ps2_key_event.sv
// ps2_key_event: pops PS/2 scan-code bytes from the receiver FIFO and folds
// E0/F0/E1 prefixes into one key event per key, with modifier/repeat tracking.
// Ports:
//   clk, clr                 clock, async active-high reset
//   kb_data, kb_ready        FIFO head byte and non-empty flag
//   kb_nextdata_n            registered pop strobe, low one cycle per byte
//   ev_valid, ev_ready       event register handshake
//   ev_code/ev_break/ev_ext  key code and prefix flags of the event
//   ev_repeat, ev_mods       typematic flag, {caps,alt,ctrl,shift} after event
//   ev_count                 non-repeat press counter (wraps)
//   shift_o/ctrl_o/alt_o/caps_o  live modifier levels
module ps2_key_event #(
    parameter int unsigned PAUSE_SKIP = 7,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_break,
    output logic             ev_ext,
    output logic             ev_repeat,
    output logic [3:0]       ev_mods,
    output logic [CNT_W-1:0] ev_count,
    output logic             shift_o,
    output logic             ctrl_o,
    output logic             alt_o,
    output logic             caps_o
);

    localparam int SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_GAP
    } state_t;

    state_t state, state_d;
    logic   pop_go;

    logic [7:0]        byte_q;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              lshift_q, lshift_d;
    logic              rshift_q, rshift_d;
    logic              lctrl_q, lctrl_d;
    logic              rctrl_q, rctrl_d;
    logic              lalt_q, lalt_d;
    logic              ralt_q, ralt_d;
    logic              caps_q, caps_d;
    logic              held_v_q, held_v_d;
    logic [8:0]        held_q, held_d;
    logic [CNT_W-1:0]  cnt_d;

    logic              emit;
    logic              rep;
    logic              same;
    logic              mk;
    logic [8:0]        key;
    logic [3:0]        mods_d;
    logic              is_e1, is_e0, is_f0, is_noise;

    // Event decoded in POP waits here one cycle and enters the output
    // register in GAP; the register is always free by then because the
    // pop was only issued when it was empty or draining.
    logic              pend_v;
    logic [7:0]        pend_code;
    logic              pend_brk;
    logic              pend_ext;
    logic              pend_rep;
    logic [3:0]        pend_mods;

    always_comb begin
        state_d = state;
        pop_go  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (kb_ready && !(ev_valid && !ev_ready)) begin
                    pop_go  = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_d;
    end

    assign is_e1    = (byte_q == 8'hE1);
    assign is_e0    = (byte_q == 8'hE0);
    assign is_f0    = (byte_q == 8'hF0);
    assign is_noise = (byte_q == 8'h00) || (byte_q == 8'hAA) ||
                      (byte_q == 8'hFA) || (byte_q == 8'hFE) ||
                      (byte_q == 8'hFF);
    assign key      = {ext_q, byte_q};
    assign same     = held_v_q && (held_q == key);
    assign mk       = !brk_q;

    always_comb begin
        skip_d   = skip_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        lalt_d   = lalt_q;
        ralt_d   = ralt_q;
        caps_d   = caps_q;
        held_v_d = held_v_q;
        held_d   = held_q;
        cnt_d    = ev_count;
        emit     = 1'b0;
        rep      = 1'b0;
        if (state == S_POP) begin
            if (skip_q != '0) begin
                skip_d = skip_q - SKIP_W'(1);
            end else begin
                unique case (1'b1)
                    is_e1: begin
                        skip_d = SKIP_W'(PAUSE_SKIP);
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                    is_e0: ext_d = 1'b1;
                    is_f0: brk_d = 1'b1;
                    is_noise: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        emit  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                        if (!brk_q) begin
                            rep = same;
                            if (!same) begin
                                held_d   = key;
                                held_v_d = 1'b1;
                                cnt_d    = ev_count + CNT_W'(1);
                                if (key == 9'h058) caps_d = !caps_q;
                            end
                        end else if (same) begin
                            held_v_d = 1'b0;
                        end
                        // Each physical modifier key has its own level.
                        case (key)
                            9'h012:  lshift_d = mk;
                            9'h059:  rshift_d = mk;
                            9'h014:  lctrl_d  = mk;
                            9'h114:  rctrl_d  = mk;
                            9'h011:  lalt_d   = mk;
                            9'h111:  ralt_d   = mk;
                            default: ;
                        endcase
                    end
                endcase
            end
        end
        mods_d = {caps_d, lalt_d | ralt_d, lctrl_d | rctrl_d,
                  lshift_d | rshift_d};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            kb_nextdata_n <= 1'b1;
            byte_q        <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            skip_q        <= '0;
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            lctrl_q       <= 1'b0;
            rctrl_q       <= 1'b0;
            lalt_q        <= 1'b0;
            ralt_q        <= 1'b0;
            caps_q        <= 1'b0;
            held_v_q      <= 1'b0;
            held_q        <= '0;
            ev_count      <= '0;
            pend_v        <= 1'b0;
            pend_code     <= '0;
            pend_brk      <= 1'b0;
            pend_ext      <= 1'b0;
            pend_rep      <= 1'b0;
            pend_mods     <= '0;
            ev_valid      <= 1'b0;
            ev_code       <= '0;
            ev_break      <= 1'b0;
            ev_ext        <= 1'b0;
            ev_repeat     <= 1'b0;
            ev_mods       <= '0;
        end else begin
            kb_nextdata_n <= !pop_go;
            if (pop_go) byte_q <= kb_data;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            skip_q   <= skip_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            lctrl_q  <= lctrl_d;
            rctrl_q  <= rctrl_d;
            lalt_q   <= lalt_d;
            ralt_q   <= ralt_d;
            caps_q   <= caps_d;
            held_v_q <= held_v_d;
            held_q   <= held_d;
            ev_count <= cnt_d;
            pend_v   <= emit;
            if (emit) begin
                pend_code <= byte_q;
                pend_brk  <= brk_q;
                pend_ext  <= ext_q;
                pend_rep  <= rep;
                pend_mods <= mods_d;
            end
            if (pend_v && (!ev_valid || ev_ready)) begin
                ev_valid  <= 1'b1;
                ev_code   <= pend_code;
                ev_break  <= pend_brk;
                ev_ext    <= pend_ext;
                ev_repeat <= pend_rep;
                ev_mods   <= pend_mods;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

    assign shift_o = lshift_q | rshift_q;
    assign ctrl_o  = lctrl_q | rctrl_q;
    assign alt_o   = lalt_q | ralt_q;
    assign caps_o  = caps_q;

endmodule
